// File: rtl/shared_bus_arbiter.sv
// Multi-core shared read bus: round-robin arbiter with time-slice quantum and lock,
// driving a registered, zero-extended source-select data path.
module shared_bus_arbiter #(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned NUM_SRC   = 17,
  parameter int unsigned SEL_W     = 5,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned QUANTUM   = 8,
  parameter int unsigned OWN_W     = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CORES-1:0]         req,
  input  logic [NUM_CORES-1:0]         lock,
  input  logic [NUM_CORES*SEL_W-1:0]   sel,
  input  logic [NUM_SRC*DATA_W-1:0]    src_data,
  output logic [NUM_CORES-1:0]         grant,
  output logic [OWN_W-1:0]             owner,
  output logic                         busy,
  output logic [DATA_W-1:0]            bus_out,
  output logic                         bus_valid,
  output logic                         sel_err
);

  localparam int unsigned HOLD_W = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(QUANTUM - 1);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t                state, state_n;
  logic [NUM_CORES-1:0]  grant_n;
  logic [OWN_W-1:0]      owner_n;
  logic [OWN_W-1:0]      rr_ptr, rr_ptr_n;
  logic [HOLD_W-1:0]     hold, hold_n;
  logic [OWN_W-1:0]      pick_idx;
  logic [NUM_CORES-1:0]  others;
  logic [SEL_W-1:0]      sel_owner;
  logic [DATA_W-1:0]     src_word;
  logic                  sel_ok;

  function automatic logic [OWN_W-1:0] next_idx(input logic [OWN_W-1:0] i);
    return (i == OWN_W'(NUM_CORES - 1)) ? '0 : i + OWN_W'(1);
  endfunction

  // Rotate the request vector so the search starts at 'start', then map the hit back.
  function automatic logic [OWN_W-1:0] rr_pick(input logic [NUM_CORES-1:0] r,
                                               input logic [OWN_W-1:0]     start);
    logic [2*NUM_CORES-1:0] dbl;
    logic [OWN_W:0]         idx;
    logic [OWN_W-1:0]       res;
    logic                   hit;
    dbl = {r, r} >> start;
    idx = '0;
    res = '0;
    hit = 1'b0;
    for (int unsigned off = 0; off < NUM_CORES; off++) begin
      if (!hit && dbl[off]) begin
        hit = 1'b1;
        idx = {1'b0, start} + (OWN_W+1)'(off);
        if (idx >= (OWN_W+1)'(NUM_CORES)) idx = idx - (OWN_W+1)'(NUM_CORES);
        res = idx[OWN_W-1:0];
      end
    end
    return res;
  endfunction

  assign busy   = (state == OWNED);
  assign others = req & ~grant;

  always_comb begin
    state_n  = state;
    grant_n  = grant;
    owner_n  = owner;
    rr_ptr_n = rr_ptr;
    hold_n   = hold;
    pick_idx = '0;
    case (state)
      IDLE: begin
        if (|req) begin
          pick_idx = rr_pick(req, rr_ptr);
          state_n  = OWNED;
          owner_n  = pick_idx;
          grant_n  = NUM_CORES'(1) << pick_idx;
          hold_n   = '0;
        end
      end
      OWNED: begin
        if (!req[owner]) begin
          state_n  = IDLE;
          grant_n  = '0;
          rr_ptr_n = next_idx(owner);
          hold_n   = '0;
        end else if (!lock[owner] && (hold == HOLD_MAX) && (|others)) begin
          pick_idx = rr_pick(others, next_idx(owner));
          owner_n  = pick_idx;
          grant_n  = NUM_CORES'(1) << pick_idx;
          rr_ptr_n = next_idx(owner);
          hold_n   = '0;
        end else if (hold != HOLD_MAX) begin
          hold_n = hold + HOLD_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    sel_owner = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (owner == OWN_W'(i)) sel_owner = sel[i*SEL_W +: SEL_W];
    end
  end

  always_comb begin
    src_word = '0;
    sel_ok   = 1'b0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (sel_owner == SEL_W'(k)) begin
        src_word = src_data[k*DATA_W +: DATA_W];
        sel_ok   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant     <= '0;
      owner     <= '0;
      rr_ptr    <= '0;
      hold      <= '0;
      bus_out   <= '0;
      bus_valid <= 1'b0;
      sel_err   <= 1'b0;
    end else begin
      state  <= state_n;
      grant  <= grant_n;
      owner  <= owner_n;
      rr_ptr <= rr_ptr_n;
      hold   <= hold_n;
      if (busy) begin
        bus_out   <= sel_ok ? src_word : '0;
        bus_valid <= sel_ok;
        sel_err   <= !sel_ok;
      end else begin
        bus_valid <= 1'b0;
        sel_err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_shared_bus_arbiter.sv
// Directed self-checking bench for shared_bus_arbiter: reset, single owner,
// round-robin quantum, lock, release bubble and bad-select handling.
module tb_shared_bus_arbiter;

  localparam int unsigned NUM_CORES = 4;
  localparam int unsigned NUM_SRC   = 17;
  localparam int unsigned SEL_W     = 5;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned QUANTUM   = 8;
  localparam int unsigned OWN_W     = 2;

  logic                       clk;
  logic                       rst_n;
  logic [NUM_CORES-1:0]       req;
  logic [NUM_CORES-1:0]       lock;
  logic [NUM_CORES*SEL_W-1:0] sel;
  logic [NUM_SRC*DATA_W-1:0]  src_data;
  logic [NUM_CORES-1:0]       grant;
  logic [OWN_W-1:0]           owner;
  logic                       busy;
  logic [DATA_W-1:0]          bus_out;
  logic                       bus_valid;
  logic                       sel_err;

  int checks = 0;
  int errors = 0;

  shared_bus_arbiter #(
    .NUM_CORES(NUM_CORES),
    .NUM_SRC  (NUM_SRC),
    .SEL_W    (SEL_W),
    .DATA_W   (DATA_W),
    .QUANTUM  (QUANTUM),
    .OWN_W    (OWN_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .lock     (lock),
    .sel      (sel),
    .src_data (src_data),
    .grant    (grant),
    .owner    (owner),
    .busy     (busy),
    .bus_out  (bus_out),
    .bus_valid(bus_valid),
    .sel_err  (sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] src_val(input int unsigned k);
    if (k == 5)  return 16'h00A7;
    if (k == 16) return 16'h1234;
    return 16'hC000 | DATA_W'(k);
  endfunction

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic set_sel(input int unsigned core, input logic [SEL_W-1:0] v);
    sel[core*SEL_W +: SEL_W] = v;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    req   = '0;
    lock  = '0;
    sel   = '0;
    repeat (2) tick;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req   = NUM_CORES'($urandom);
    lock  = NUM_CORES'($urandom);
    sel   = (NUM_CORES*SEL_W)'($urandom);
    repeat (3) tick;
    checks++;
    if ({grant, owner, busy} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got grant=%b owner=%0d busy=%b want 0 0 0", grant, owner, busy);
    end
    checks++;
    if ({bus_out, bus_valid, sel_err} !== 18'b0) begin
      errors++;
      $display("FAIL reset_data: got bus_out=%h valid=%b err=%b want 0 0 0", bus_out, bus_valid, sel_err);
    end
    do_reset;
  endtask

  task automatic test_single;
    do_reset;
    set_sel(2, 5'd5);
    req = 4'b0100;
    tick;
    checks++;
    if ({grant, owner, busy} !== {4'b0100, 2'd2, 1'b1}) begin
      errors++;
      $display("FAIL single_grant: got grant=%b owner=%0d busy=%b want 0100 2 1", grant, owner, busy);
    end
    checks++;
    if (bus_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_latency: got bus_valid=%b want 0", bus_valid);
    end
    tick;
    checks++;
    if ({bus_out, bus_valid, sel_err} !== {16'h00A7, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL single_src5: got %h/%b/%b want 00a7/1/0", bus_out, bus_valid, sel_err);
    end
    set_sel(2, 5'd16);
    tick;
    checks++;
    if ({bus_out, bus_valid} !== {16'h1234, 1'b1}) begin
      errors++;
      $display("FAIL single_src16: got %h/%b want 1234/1", bus_out, bus_valid);
    end
    req = '0;
    tick;
    checks++;
    if ({grant, busy} !== 5'b0) begin
      errors++;
      $display("FAIL single_release: got grant=%b busy=%b want 0000 0", grant, busy);
    end
    tick;
    checks++;
    if ({bus_out, bus_valid} !== {16'h1234, 1'b0}) begin
      errors++;
      $display("FAIL single_hold: got %h/%b want 1234/0", bus_out, bus_valid);
    end
  endtask

  task automatic test_round_robin;
    do_reset;
    req = 4'b1111;
    for (int n = 0; n < 33; n++) begin
      int unsigned e;
      logic [3:0]  eg;
      logic [1:0]  eo;
      tick;
      e  = (n / 8) % 4;
      eg = 4'(1 << e);
      eo = 2'(e);
      checks++;
      if ({grant, owner, busy} !== {eg, eo, 1'b1}) begin
        errors++;
        $display("FAIL rr_cycle%0d: got grant=%b owner=%0d busy=%b want %b %0d 1", n, grant, owner, busy, eg, eo);
      end
    end
    req = '0;
  endtask

  task automatic test_lock;
    do_reset;
    req  = 4'b1010;
    lock = 4'b0010;
    for (int n = 0; n < 20; n++) begin
      tick;
      checks++;
      if ({grant, owner} !== {4'b0010, 2'd1}) begin
        errors++;
        $display("FAIL lock_hold%0d: got grant=%b owner=%0d want 0010 1", n, grant, owner);
      end
    end
    lock = '0;
    tick;
    checks++;
    if ({grant, owner, busy} !== {4'b1000, 2'd3, 1'b1}) begin
      errors++;
      $display("FAIL lock_drop: got grant=%b owner=%0d busy=%b want 1000 3 1", grant, owner, busy);
    end
    req = '0;
  endtask

  task automatic test_release_bubble;
    do_reset;
    req = 4'b0001;
    tick;
    checks++;
    if ({grant, owner} !== {4'b0001, 2'd0}) begin
      errors++;
      $display("FAIL rel_first: got grant=%b owner=%0d want 0001 0", grant, owner);
    end
    req = 4'b0011;
    tick;
    checks++;
    if (grant !== 4'b0001) begin
      errors++;
      $display("FAIL rel_keep: got grant=%b want 0001", grant);
    end
    req = 4'b0010;
    tick;
    checks++;
    if ({grant, busy} !== 5'b0) begin
      errors++;
      $display("FAIL rel_bubble: got grant=%b busy=%b want 0000 0", grant, busy);
    end
    tick;
    checks++;
    if ({grant, owner, busy} !== {4'b0010, 2'd1, 1'b1}) begin
      errors++;
      $display("FAIL rel_next: got grant=%b owner=%0d busy=%b want 0010 1 1", grant, owner, busy);
    end
    tick;
    checks++;
    if ({bus_out, bus_valid} !== {src_val(0), 1'b1}) begin
      errors++;
      $display("FAIL rel_data: got %h/%b want %h/1", bus_out, bus_valid, src_val(0));
    end
    rst_n = 1'b0;
    tick;
    checks++;
    if ({grant, busy, bus_valid, bus_out} !== 22'b0) begin
      errors++;
      $display("FAIL mid_reset: got grant=%b busy=%b valid=%b bus_out=%h want all 0", grant, busy, bus_valid, bus_out);
    end
    rst_n = 1'b1;
    req   = '0;
  endtask

  task automatic test_bad_sel;
    do_reset;
    set_sel(0, 5'd3);
    req = 4'b0001;
    tick;
    tick;
    checks++;
    if ({bus_out, bus_valid, sel_err} !== {src_val(3), 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL badsel_pre: got %h/%b/%b want %h/1/0", bus_out, bus_valid, sel_err, src_val(3));
    end
    set_sel(0, 5'd20);
    tick;
    checks++;
    if ({bus_out, bus_valid, sel_err} !== {16'h0000, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL badsel_err: got %h/%b/%b want 0000/0/1", bus_out, bus_valid, sel_err);
    end
    set_sel(0, 5'd0);
    tick;
    checks++;
    if ({bus_out, bus_valid, sel_err} !== {src_val(0), 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL badsel_recover: got %h/%b/%b want %h/1/0", bus_out, bus_valid, sel_err, src_val(0));
    end
    req = '0;
    tick;
    tick;
    checks++;
    if ({bus_valid, sel_err, busy} !== 3'b0) begin
      errors++;
      $display("FAIL badsel_idle: got valid=%b err=%b busy=%b want 0 0 0", bus_valid, sel_err, busy);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    lock  = '0;
    sel   = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) src_data[k*DATA_W +: DATA_W] = src_val(k);
    test_reset;
    test_single;
    test_round_robin;
    test_lock;
    test_release_bubble;
    test_bad_sel;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shared_bus_arbiter.md
Name: shared_bus_arbiter

Overview:
- Parametrised successor to the single-master source-select bus, for the multi-core multiplier.
- NUM_CORES cores share one read bus. Each core requests ownership and presents its own source select.
- A round-robin arbiter with time-slice quantum and lock grants one owner. The selected source word is registered onto a zero-extended DATA_W bus with a valid flag and an out-of-range select error.

Parameters:
- NUM_CORES, 4, number of requesting cores (2..8)
- NUM_SRC, 17, number of bus sources; select codes 0..NUM_SRC-1 are valid
- SEL_W, 5, select code width; must satisfy 2^SEL_W >= NUM_SRC
- DATA_W, 16, bus width; every source slot is DATA_W wide, narrower sources are zero-extended by the instantiator
- QUANTUM, 8, maximum consecutive owned cycles when other cores are waiting and lock is low
- OWN_W, 2, owner index width; 2^OWN_W >= NUM_CORES

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- req  in  NUM_CORES  per-core bus request, level
- lock  in  NUM_CORES  per-core lock; while the owner holds lock high, quantum preemption is disabled
- sel  in  NUM_CORES*SEL_W  per-core source select; core i occupies bits [i*SEL_W +: SEL_W]
- src_data  in  NUM_SRC*DATA_W  flattened sources; source k occupies bits [k*DATA_W +: DATA_W]
- grant  out  NUM_CORES  one-hot owner, registered
- owner  out  OWN_W  binary index of the current owner, valid when busy=1
- busy  out  1  1 while any core is granted
- bus_out  out  DATA_W  registered bus data
- bus_valid  out  1  bus_out carries the owner's selected source
- sel_err  out  1  one-cycle pulse, owner's select was >= NUM_SRC

Behaviour:
- Reset (rst_n=0 at an edge), including mid-transfer:
  - grant=0, owner=0, busy=0, bus_out=0, bus_valid=0, sel_err=0
  - rr pointer=0, hold counter=0, state=IDLE
  - No partial transfer survives reset.
- State machine with two states, IDLE and OWNED:
  - IDLE: if any req bit is set, pick the first requesting core at or after the rr pointer, wrapping modulo NUM_CORES. At the next edge go to OWNED, set grant one-hot, owner, busy=1, hold=0. Otherwise stay in IDLE.
  - OWNED, release: owner's req=0 → next edge grant=0, busy=0, rr pointer=owner+1 (wraps), state=IDLE. Re-arbitration happens in the following IDLE cycle, so there is exactly 1 idle bubble after a release.
  - OWNED, preempt: owner's req=1, lock=0, hold==QUANTUM-1 and another req bit is set → hand over directly at the next edge, with no bubble. The new owner is the next requester after the current owner (round-robin), hold resets to 0, and the rr pointer moves past the old owner.
  - OWNED, continue: all other cases keep the owner and hold increments, saturating at QUANTUM-1.
  - If the quantum has expired but no other requester exists, the owner keeps the bus. The owner is preempted in the cycle a competitor appears, provided lock=0.
  - Lock high: the owner is never preempted. It is still released when its req drops.
- Data path, 1-cycle latency from grant:
  - At each edge where busy=1 at the sampling edge (the registered grant is already set): bus_out <= src_data[sel_owner], bus_valid <= 1.
  - If sel_owner >= NUM_SRC: bus_out <= 0, bus_valid <= 0, sel_err <= 1 for that cycle.
  - When busy=0: bus_valid <= 0, sel_err <= 0, and bus_out holds its last value.
  - The select is re-sampled every cycle, so the owner may change source cycle by cycle.
- Timing: req asserted at cycle N, arbiter idle → grant at N+1 → first valid bus_out at N+2.
- Simultaneous events:
  - Owner release and a new request in the same cycle: the release wins and the new request is served after the bubble.
  - Multiple simultaneous requests: resolved only by the rr pointer.
- grant is always zero or one-hot. owner always matches grant when busy=1.

Test Plan:
- Reset: drive random req/sel, hold rst_n=0 for 3 cycles → all outputs 0. Assert rst_n=0 mid-ownership → grant=0 and bus_valid=0 at the next edge.
- Single core:
  - Core 2 raises req with sel=5, src5=16'h00A7 → grant=4'b0100 and owner=2 one cycle later, bus_out=16'h00A7 with bus_valid=1 the cycle after.
  - Change sel to 16 with src16=16'h1234 → bus_out=16'h1234 next cycle.
- Round-robin: req=4'b1111 held, lock=0, QUANTUM=8 → owner sequence 0,1,2,3,0 with each tenure exactly 8 cycles and no idle bubble between tenures.
- Lock: core 1 owns with lock=1 and core 3 requesting → core 1 keeps the grant for 20 cycles. Drop lock → grant moves to core 3 in the next cycle (quantum already expired).
- Release and bubble: owner 0 drops req while core 1 holds req → 1 cycle with busy=0, then grant=4'b0010.
- Bad select: owner sel=5'd20 → sel_err pulses, bus_valid=0, bus_out=0. Return to sel=0 → valid data the next cycle and sel_err=0.
